pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the RV32I core, the successor to the fixed 32-bit PC register. It holds the fetch address and advances it by 4 each cycle. It accepts one resolved redirect per cycle from branch, jump and AUIPC-style control, and traps misaligned targets to a fixed vector. It also keeps a small circular return-address stack (RAS) that scores return predictions. It sits between the control/ALU datapath and instruction memory.

## Interface
- XLEN, 32, address width in bits.
- RESET_VEC, 0, value loaded into pc_out on reset.
- TRAP_VEC, 32'h0000_0100, next PC after a misaligned redirect.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- stall, in, 1, hold all state this cycle.
- redir_valid, in, 1, take redir_target instead of pc_out+4.
- redir_target, in, XLEN, resolved redirect address.
- push_link, in, 1, qualified by redir_valid: push pc_out+4 (call).
- pop_ret, in, 1, qualified by redir_valid: pop RAS (return).
- pc_out, out, XLEN, current fetch address.
- pc_plus4, out, XLEN, combinational pc_out+4, modulo 2^XLEN.
- misalign_trap, out, 1, registered one-cycle pulse.
- bad_addr, out, XLEN, last misaligned target.
- ras_top, out, XLEN, current top-of-stack; 0 when empty.
- ras_hit, out, 1, registered; set when the last pop returned a value equal to redir_target.
- ras_empty, out, 1, RAS count is 0.
- ras_full, out, 1, RAS count equals RAS_DEPTH.

## Operation
- **Reset values:** pc_out=RESET_VEC; misalign_trap=0; bad_addr=0; ras_hit=0; RAS count=0 and every entry 0; ras_empty=1; ras_full=0.
- **stall=1:** all registers hold and every other input is ignored. misalign_trap and ras_hit hold their values.
- **Priority when not stalled:**
  1. redir_valid with redir_target[1:0]≠0: pc_out←TRAP_VEC, bad_addr←redir_target, misalign_trap←1. RAS is untouched and ras_hit←0.
  2. redir_valid with an aligned target: pc_out←redir_target, and RAS operations apply.
  3. Otherwise: pc_out←pc_out+4, wrapping from all-ones−3 to 0. misalign_trap←0 and ras_hit←0.
- push_link and pop_ret are ignored when redir_valid=0.
- **Push only:**
  - entry[top+1]←pc_out+4 and count←count+1.
  - When full, the pointer wraps and the oldest entry is overwritten. Count saturates at RAS_DEPTH.
- **Pop only:**
  - Non-empty: ras_hit←(ras_top==redir_target), pointer decrements, count←count−1.
  - Empty: no change and ras_hit←0.
- **Push and pop together** (coroutine jump):
  - ras_hit is computed against the old top.
  - The top entry is replaced by pc_out+4.
  - Count and pointer are unchanged. If the RAS was empty, it behaves as a push only.
- The redirect target is never replaced by ras_top. The RAS only scores predictions.

## Timing
- pc_out changes only at the rising edge of clk, or asynchronously when rst falls. A redirect presented in cycle N appears on pc_out in cycle N+1.
- pc_plus4, ras_top, ras_empty and ras_full are combinational from state.
- misalign_trap and ras_hit are valid in the cycle after the causing redirect and last exactly one unstalled cycle.
- Asserting rst mid-operation clears the RAS and pc_out immediately. The first post-reset edge, if not stalled, advances to RESET_VEC+4.

## Structure
- Package pc_pkg holds:
  - default XLEN;
  - INSN_BYTES=4;
  - RESET_VEC and TRAP_VEC defaults;
  - the alignment-mask constant.
- Sub-module ras_stack (parameters XLEN and RAS_DEPTH) holds the circular pointer, the saturating count, the entries and the push/pop/replace logic.
- The pc_gen top holds the PC register, the next-PC mux, the trap registers and ras_hit.

## Test plan
- **Reset and sequential fetch:** RESET_VEC=0 with no redirects for 3 cycles → pc_out 0, 4, 8, 12. Assert rst mid-run → pc_out=0 at once and ras_empty=1.
- **Wrap and stall:** pc_out=32'hFFFF_FFFC, one cycle → pc_out=0. Then stall=1 with redir_valid=1 and target 0x40 → pc_out stays 0.
- **Misalignment:** redirect to 0x202 → next cycle pc_out=0x100, misalign_trap=1, bad_addr=0x202, RAS unchanged. On the following cycle misalign_trap=0.
- **Call/return hit:** at pc 0x10, push_link with target 0x80 → ras_top=0x14. Later pop_ret with target 0x14 → ras_hit=1 and ras_empty=1. Pop with target 0x18 after another push of 0x14 → ras_hit=0.
- **Overflow:** RAS_DEPTH=4, push five calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_full=1 and ras_top=0x44. Four pops → tops 0x44, 0x34, 0x24, 0x14, and the original 0x04 is lost. A fifth pop on empty → no change and ras_hit=0.
- **Push and pop together:** with ras_top=0x24, redirect at pc 0x50 with push_link=pop_ret=1 → ras_top=0x54 and count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter generator and its
// return-address stack.
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam int          INSN_BYTES    = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
  localparam logic [1:0]  ALIGN_MASK    = 2'b11;

  typedef enum logic [1:0] {
    RAS_NONE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2,
    RAS_REPL = 2'd3
  } ras_op_e;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is a no-op, replace swaps the top entry in place.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  ras_op_e         op,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ent_q [RAS_DEPTH];
  logic [XLEN-1:0]  ent_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_inc;
  logic             do_push;

  assign empty    = (cnt_q == {CNT_W{1'b0}});
  assign full     = (cnt_q == CNT_MAX);
  assign top_data = empty ? {XLEN{1'b0}} : ent_q[ptr_q];

  // Next-state for pointer, count and entries
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    ptr_inc = ptr_q + PTR_ONE;
    // A replace on an empty stack has no top to replace, so it pushes.
    do_push = (op == RAS_PUSH) || ((op == RAS_REPL) && empty);
    if (do_push) begin
      ptr_d          = ptr_inc;
      ent_d[ptr_inc] = push_data;
      cnt_d          = full ? cnt_q : (cnt_q + CNT_ONE);
    end else if ((op == RAS_POP) && !empty) begin
      ptr_d = ptr_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end else if (op == RAS_REPL) begin
      ent_d[ptr_q] = push_data;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ent_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, resolved redirects, misaligned
// target trap and a return-address stack that scores return predictions.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            push_link,
  input  logic            pop_ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_hit,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            trap_q, trap_d;
  logic            hit_q, hit_d;
  ras_op_e         ras_op;

  assign pc_plus4      = pc_q + XLEN'(INSN_BYTES);
  assign pc_out        = pc_q;
  assign bad_addr      = bad_q;
  assign misalign_trap = trap_q;
  assign ras_hit       = hit_q;

  // Next PC, trap capture, hit scoring and RAS operation select
  always_comb begin
    pc_d   = pc_q;
    bad_d  = bad_q;
    trap_d = trap_q;
    hit_d  = hit_q;
    ras_op = RAS_NONE;
    if (stall) begin
      pc_d = pc_q;
    end else if (redir_valid && is_misaligned(redir_target[1:0])) begin
      pc_d   = TRAP_VEC;
      bad_d  = redir_target;
      trap_d = 1'b1;
      hit_d  = 1'b0;
    end else if (redir_valid) begin
      pc_d   = redir_target;
      trap_d = 1'b0;
      // The target is never replaced by the prediction; it is only scored.
      case ({push_link, pop_ret})
        2'b10: begin
          ras_op = RAS_PUSH;
          hit_d  = 1'b0;
        end
        2'b01: begin
          ras_op = RAS_POP;
          hit_d  = !ras_empty && (ras_top == redir_target);
        end
        2'b11: begin
          ras_op = RAS_REPL;
          hit_d  = !ras_empty && (ras_top == redir_target);
        end
        default: begin
          ras_op = RAS_NONE;
          hit_d  = 1'b0;
        end
      endcase
    end else begin
      pc_d   = pc_plus4;
      trap_d = 1'b0;
      hit_d  = 1'b0;
    end
  end

  // PC, trap and hit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_VEC;
      bad_q  <= {XLEN{1'b0}};
      trap_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      bad_q  <= bad_d;
      trap_q <= trap_d;
      hit_q  <= hit_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst),
    .op        (ras_op),
    .push_data (pc_plus4),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst, stall, redir_valid, push_link, pop_ret;
  logic [31:0] redir_target;
  logic [31:0] pc_out, pc_plus4, bad_addr, ras_top;
  logic        misalign_trap, ras_hit, ras_empty, ras_full;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_bad;
  logic        m_trap, m_hit;
  logic [31:0] ras[$];

  pc_gen #(.XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .push_link(push_link), .pop_ret(pop_ret),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .misalign_trap(misalign_trap),
    .bad_addr(bad_addr), .ras_top(ras_top), .ras_hit(ras_hit),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    if (ras.size() == 0) return 32'h0;
    else return ras[$];
  endfunction

  task automatic model_reset();
    m_pc = RESET_VEC; m_bad = 32'h0; m_trap = 1'b0; m_hit = 1'b0;
    ras.delete();
  endtask

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                      input logic pu, input logic po);
    logic [31:0] link;
    stall = st; redir_valid = rv; redir_target = tgt; push_link = pu; pop_ret = po;
    if (!st) begin
      link = m_pc + 32'd4;
      if (rv && tgt[1:0] != 2'b00) begin
        m_pc = TRAP_VEC; m_bad = tgt; m_trap = 1'b1; m_hit = 1'b0;
      end else if (rv) begin
        if (pu && po) begin
          if (ras.size() == 0) begin ras.push_back(link); m_hit = 1'b0; end
          else begin m_hit = (ras[$] == tgt); ras[$] = link; end
        end else if (pu) begin
          ras.push_back(link);
          if (ras.size() > DEPTH) void'(ras.pop_front());
          m_hit = 1'b0;
        end else if (po) begin
          if (ras.size() > 0) begin m_hit = (ras[$] == tgt); void'(ras.pop_back()); end
          else m_hit = 1'b0;
        end else m_hit = 1'b0;
        m_pc = tgt; m_trap = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4; m_trap = 1'b0; m_hit = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0; push_link = 1'b0; pop_ret = 1'b0;
    rst = 1'b0; model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_plus4: got %h want %h", pc_plus4, 32'h4); end
    n_cmp++; if ({misalign_trap, ras_hit, ras_empty, ras_full} !== 4'b0010) begin
      n_err++; $display("FAIL rst_flags: got %b want %b", {misalign_trap, ras_hit, ras_empty, ras_full}, 4'b0010); end
    n_cmp++; if ({bad_addr, ras_top} !== 64'h0) begin n_err++; $display("FAIL rst_regs: got %h want 0", {bad_addr, ras_top}); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = 32'd4 * i;
      n_cmp++; if (pc_out !== exp) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_out, exp); end
    end
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    n_cmp++; if (ras_top !== 32'h10) begin n_err++; $display("FAIL seq_push: got %h want %h", ras_top, 32'h10); end
    #2 rst = 1'b0; model_reset();
    #1;
    n_cmp++; if (pc_out !== 32'h0 || ras_empty !== 1'b1) begin
      n_err++; $display("FAIL async_rst: got pc %h empty %b want 0 1", pc_out, ras_empty); end
    @(posedge clk); #1; rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL post_rst: got %h want %h", pc_out, 32'h4); end
  endtask

  task automatic test_wrap_stall();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
    n_cmp++; if (pc_out !== 32'h0 || ras_empty !== 1'b1) begin
      n_err++; $display("FAIL stall_hold: got pc %h empty %b want 0 1", pc_out, ras_empty); end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h202, 1'b1, 1'b1);
    n_cmp++; if (pc_out !== 32'h100 || misalign_trap !== 1'b1 || bad_addr !== 32'h202) begin
      n_err++; $display("FAIL misalign: got pc %h trap %b bad %h want 100 1 202", pc_out, misalign_trap, bad_addr); end
    n_cmp++; if (ras_top !== 32'h4 || ras_empty !== 1'b0) begin
      n_err++; $display("FAIL misalign_ras: got top %h empty %b want 4 0", ras_top, ras_empty); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (misalign_trap !== 1'b1) begin n_err++; $display("FAIL trap_stall: got %b want 1", misalign_trap); end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (misalign_trap !== 1'b0 || pc_out !== 32'h104 || bad_addr !== 32'h202) begin
      n_err++; $display("FAIL trap_clear: got trap %b pc %h bad %h want 0 104 202", misalign_trap, pc_out, bad_addr); end
  endtask

  task automatic test_call_return();
    do_reset();
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    n_cmp++; if (ras_top !== 32'h14) begin n_err++; $display("FAIL call_top: got %h want 14", ras_top); end
    step(1'b0, 1'b1, 32'h14, 1'b0, 1'b1);
    n_cmp++; if (ras_hit !== 1'b1 || ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ret_hit: got hit %b empty %b want 1 1", ras_hit, ras_empty); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL hit_stall: got %b want 1", ras_hit); end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL hit_pulse: got %b want 0", ras_hit); end
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h18, 1'b0, 1'b1);
    n_cmp++; if (ras_hit !== 1'b0 || ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ret_miss: got hit %b empty %b want 0 1", ras_hit, ras_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h10 * i, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    end
    n_cmp++; if (ras_full !== 1'b1 || ras_top !== 32'h44) begin
      n_err++; $display("FAIL ovf_full: got full %b top %h want 1 44", ras_full, ras_top); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'h44 - 32'h10 * i;
      n_cmp++; if (ras_top !== exp) begin n_err++; $display("FAIL ovf_top%0d: got %h want %h", i, ras_top, exp); end
      step(1'b0, 1'b1, exp, 1'b0, 1'b1);
      n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL ovf_hit%0d: got %b want 1", i, ras_hit); end
    end
    n_cmp++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_err++; $display("FAIL ovf_empty: got empty %b full %b want 1 0", ras_empty, ras_full); end
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b1);
    n_cmp++; if (ras_hit !== 1'b0 || ras_empty !== 1'b1 || ras_top !== 32'h0) begin
      n_err++; $display("FAIL pop_empty: got hit %b empty %b top %h want 0 1 0", ras_hit, ras_empty, ras_top); end
  endtask

  task automatic test_push_pop();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h10 * i, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    end
    n_cmp++; if (ras_top !== 32'h24) begin n_err++; $display("FAIL pp_pre: got %h want 24", ras_top); end
    step(1'b0, 1'b1, 32'h50, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h24, 1'b1, 1'b1);
    n_cmp++; if (ras_top !== 32'h54 || ras_hit !== 1'b1) begin
      n_err++; $display("FAIL pp_repl: got top %h hit %b want 54 1", ras_top, ras_hit); end
    for (int i = 0; i < 3; i++) begin
      exp = (i == 0) ? 32'h54 : (32'h24 - 32'h10 * i);
      n_cmp++; if (ras_top !== exp || ras_empty !== 1'b0) begin
        n_err++; $display("FAIL pp_cnt%0d: got top %h empty %b want %h 0", i, ras_top, ras_empty, exp); end
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    end
    n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL pp_drain: got %b want 1", ras_empty); end
    step(1'b0, 1'b1, 32'h60, 1'b1, 1'b1);
    n_cmp++; if (ras_top !== 32'h4 || ras_empty !== 1'b0 || ras_hit !== 1'b0) begin
      n_err++; $display("FAIL pp_empty: got top %h empty %b hit %b want 4 0 0", ras_top, ras_empty, ras_hit); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    int r;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      r = $urandom_range(0, 9);
      if (r == 0) tgt = $urandom() | 32'h1;
      else if (r <= 3 && ras.size() > 0) tgt = ras[$];
      else if (r == 4) tgt = 32'hFFFF_FFF8;
      else tgt = $urandom() & 32'h0000_0FFC;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, tgt,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      n_cmp++;
      if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4 || misalign_trap !== m_trap ||
          bad_addr !== m_bad || ras_top !== m_top() || ras_hit !== m_hit ||
          ras_empty !== (ras.size() == 0) || ras_full !== (ras.size() == DEPTH)) begin
        n_err++;
        $display("FAIL rand%0d: got pc %h trap %b bad %h top %h hit %b e %b f %b want pc %h trap %b bad %h top %h hit %b n %0d",
                 c, pc_out, misalign_trap, bad_addr, ras_top, ras_hit, ras_empty, ras_full,
                 m_pc, m_trap, m_bad, m_top(), m_hit, ras.size());
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
    push_link = 1'b0; pop_ret = 1'b0;
    test_reset();
    test_seq_fetch();
    test_wrap_stall();
    test_misalign();
    test_call_return();
    test_overflow();
    test_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
